control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Hardwired Moore sequencer that drives every control strobe of the 32-bit CPU datapath through fetch (T0–T2) and per-opcode execute steps (T3–T7), then returns to T0. It sits beside the datapath and reads IR and the branch-condition flag. Its outputs are wired one-to-one to the datapath's bus-source, register-load, select and ALU-operation inputs. It also drives the memory read/write strobes and the CON flip-flop load.

Parameters:
OPW, 5, opcode width, taken from IR[31:27]
NALU, 13, ALU one-hot op count: AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC (bit 0 to bit 12)

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
IR  in  32  instruction register contents
con  in  1  branch condition flip-flop output
src_en  out  8  bus sources {BAout, Cout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout}, bit 7 down to bit 0
dst_en  out  8  register loads {CONin, MDRin, Zin, LOin, HIin, Yin, MARin, IRin, PCin}; CONin is a separate port below, so the bits are {MDRin, Zin, LOin, HIin, Yin, MARin, IRin, PCin}
CONin  out  1  load for the CON flip-flop
gr_sel  out  3  {Gra, Grb, Grc}
Rin  out  1  general register load
Rout  out  1  general register drive
read  out  1  memory read; MDR takes Mdatain when read and MDRin are both 1
write  out  1  memory write
alu_op  out  13  one-hot ALU operation
run  out  1  0 only in HALT

Behaviour:
- Reset: clear is synchronous and active-high. While clear=1, every output is 0 except run=1, and the next state is T0. A clear in any state, including mid-execute or HALT, aborts the instruction.
- States: T0..T7 and HALT. Outputs decode from the state plus IR[31:27] only; there are no combinational paths from con.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin.
  - T2: MDRout, IRin.
  - T2 always advances to T3. IR is stable from T3 onward.
- Opcodes and execute steps:
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010: T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - addi 01011, andi 01100, ori 01101: T3 Grb Rout Yin; T4 Cout op Zin; T5 Zlowout Gra Rin. The op is ADD/AND/OR respectively.
  - mul 01110, div 01111: T3 Gra Rout Yin; T4 Grb Rout op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10000, not 10001: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - ld 00000: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 read MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
  - st 00010: T3–T5 as ld; T6 Gra Rout MDRin (read=0); T7 write.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only when con=1. T6 occurs and returns to T0 regardless of con.
  - jr 10011: T3 Gra Rout PCin.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - halt 11010: T3 goes to HALT. HALT holds all strobes at 0 and run=0 until clear.
  - nop 11001 and all other opcodes (in, out, jal, 11011–11111): T3 goes to T0 with no strobes.
- Last execute step of each instruction returns to T0. There are no waits; memory is single-cycle.
- Exclusivity: at most one src_en bit or Rout is active per state; exactly one alu_op bit is active when Zin=1, otherwise 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (5-bit)
  - state encoding (4-bit: T0..T7, HALT)
  - src_en/dst_en bit indices
  - alu_op bit indices
- Sub-module ctrl_decode: combinational state+opcode to strobe vectors. control_unit keeps only the state register and next-state logic.

Test Plan:
- Reset then fetch: clear=1 for 2 cycles, then 0. Each cycle must show src_en/dst_en/alu_op matching the T0–T2 table; T0 has alu_op[12]=1 and Zin=1.
- add, IR=0x18918000 (add R1,R2,R3): T3 gr_sel=010 Rout Yin; T4 gr_sel=001 Rout alu_op[2] Zin; T5 Zlowout gr_sel=100 Rin; next cycle is T0.
- ld, IR=0x00800055: T5 Zlowout MARin; T6 read=1 MDRin; T7 MDRout Rin; instruction takes 8 cycles total.
- br, con=0 then con=1: T6 PCin=0 for con=0 and PCin=1 for con=1; both return to T0 after T6.
- mul, IR=opcode 01110: T5 LOin; T6 HIin; src_en selects Zlowout then Zhighout.
- halt, then clear mid-HALT, then clear asserted during ld T5: run=0 after halt; after clear, T0 follows with no write or Rin pulse.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU control unit: opcodes, states,
// strobe bit positions and opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPW   = 5;
    localparam int unsigned NALU  = 13;
    localparam int unsigned NSRC  = 8;
    localparam int unsigned NDST  = 8;
    localparam int unsigned IRW   = 32;
    localparam int unsigned OP_LSB = IRW - OPW;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    // src_en bit positions
    localparam int unsigned SRC_BA   = 7;
    localparam int unsigned SRC_C    = 6;
    localparam int unsigned SRC_MDR  = 5;
    localparam int unsigned SRC_PC   = 4;
    localparam int unsigned SRC_ZLO  = 3;
    localparam int unsigned SRC_ZHI  = 2;
    localparam int unsigned SRC_LO   = 1;
    localparam int unsigned SRC_HI   = 0;

    // dst_en bit positions
    localparam int unsigned DST_MDR  = 7;
    localparam int unsigned DST_Z    = 6;
    localparam int unsigned DST_LO   = 5;
    localparam int unsigned DST_HI   = 4;
    localparam int unsigned DST_Y    = 3;
    localparam int unsigned DST_MAR  = 2;
    localparam int unsigned DST_IR   = 1;
    localparam int unsigned DST_PC   = 0;

    // gr_sel bit positions
    localparam int unsigned GR_A = 2;
    localparam int unsigned GR_B = 1;
    localparam int unsigned GR_C = 0;

    // alu_op bit positions
    localparam int unsigned ALU_AND   = 0;
    localparam int unsigned ALU_OR    = 1;
    localparam int unsigned ALU_ADD   = 2;
    localparam int unsigned ALU_SUB   = 3;
    localparam int unsigned ALU_MUL   = 4;
    localparam int unsigned ALU_DIV   = 5;
    localparam int unsigned ALU_SHR   = 6;
    localparam int unsigned ALU_SHL   = 7;
    localparam int unsigned ALU_ROR   = 8;
    localparam int unsigned ALU_ROL   = 9;
    localparam int unsigned ALU_NEG   = 10;
    localparam int unsigned ALU_NOT   = 11;
    localparam int unsigned ALU_INCPC = 12;

    typedef enum logic [3:0] {
        C_NONE, C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI,
        C_ST, C_BR, C_JR, C_MFHI, C_MFLO, C_HALT
    } op_class_t;

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:       return C_IMM;
            OP_MUL, OP_DIV:                 return C_MULDIV;
            OP_NEG, OP_NOT:                 return C_UNARY;
            OP_LD:                          return C_LD;
            OP_LDI:                         return C_LDI;
            OP_ST:                          return C_ST;
            OP_BR:                          return C_BR;
            OP_JR:                          return C_JR;
            OP_MFHI:                        return C_MFHI;
            OP_MFLO:                        return C_MFLO;
            OP_HALT:                        return C_HALT;
            default:                        return C_NONE;
        endcase
    endfunction

    // Final execute step (T3..T7) of each instruction class
    function automatic logic [2:0] last_step(input op_class_t cls);
        case (cls)
            C_ALU3, C_IMM, C_LDI: return 3'd5;
            C_MULDIV, C_BR:       return 3'd6;
            C_UNARY:              return 3'd4;
            C_LD, C_ST:           return 3'd7;
            default:              return 3'd3;
        endcase
    endfunction

    // ALU operation; address arithmetic (ld/ldi/st/br) defaults to ADD
    function automatic logic [NALU-1:0] alu_sel(input logic [OPW-1:0] op);
        logic [NALU-1:0] v;
        v = '0;
        case (op)
            OP_SUB:          v[ALU_SUB] = 1'b1;
            OP_AND, OP_ANDI: v[ALU_AND] = 1'b1;
            OP_OR, OP_ORI:   v[ALU_OR]  = 1'b1;
            OP_SHR:          v[ALU_SHR] = 1'b1;
            OP_SHL:          v[ALU_SHL] = 1'b1;
            OP_ROR:          v[ALU_ROR] = 1'b1;
            OP_ROL:          v[ALU_ROL] = 1'b1;
            OP_MUL:          v[ALU_MUL] = 1'b1;
            OP_DIV:          v[ALU_DIV] = 1'b1;
            OP_NEG:          v[ALU_NEG] = 1'b1;
            OP_NOT:          v[ALU_NOT] = 1'b1;
            default:         v[ALU_ADD] = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from the sequencer state and opcode.
// Clear forces every strobe low and keeps run high.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OPW-1:0]  op,
    input  logic            con_q,
    input  logic            clear,
    output logic [NSRC-1:0] src_en,
    output logic [NDST-1:0] dst_en,
    output logic            CONin,
    output logic [2:0]      gr_sel,
    output logic            Rin,
    output logic            Rout,
    output logic            read,
    output logic            write,
    output logic [NALU-1:0] alu_op,
    output logic            run
);

    op_class_t       cls;
    logic [NALU-1:0] op_alu;

    assign cls    = classify(op);
    assign op_alu = alu_sel(op);

    always_comb begin
        src_en = '0;
        dst_en = '0;
        CONin  = 1'b0;
        gr_sel = '0;
        Rin    = 1'b0;
        Rout   = 1'b0;
        read   = 1'b0;
        write  = 1'b0;
        alu_op = '0;
        run    = 1'b1;
        if (!clear) begin
            case (state)
                S_T0: begin
                    src_en[SRC_PC]       = 1'b1;
                    dst_en[DST_MAR]      = 1'b1;
                    dst_en[DST_Z]        = 1'b1;
                    alu_op[ALU_INCPC]    = 1'b1;
                end
                S_T1: begin
                    src_en[SRC_ZLO]      = 1'b1;
                    dst_en[DST_PC]       = 1'b1;
                    dst_en[DST_MDR]      = 1'b1;
                    read                 = 1'b1;
                end
                S_T2: begin
                    src_en[SRC_MDR]      = 1'b1;
                    dst_en[DST_IR]       = 1'b1;
                end
                S_T3: begin
                    case (cls)
                        C_ALU3, C_IMM: begin
                            gr_sel[GR_B] = 1'b1; Rout = 1'b1; dst_en[DST_Y] = 1'b1;
                        end
                        C_MULDIV: begin
                            gr_sel[GR_A] = 1'b1; Rout = 1'b1; dst_en[DST_Y] = 1'b1;
                        end
                        C_UNARY: begin
                            gr_sel[GR_B] = 1'b1; Rout = 1'b1;
                            alu_op = op_alu; dst_en[DST_Z] = 1'b1;
                        end
                        C_LD, C_LDI, C_ST: begin
                            gr_sel[GR_B] = 1'b1; src_en[SRC_BA] = 1'b1; dst_en[DST_Y] = 1'b1;
                        end
                        C_BR: begin
                            gr_sel[GR_A] = 1'b1; Rout = 1'b1; CONin = 1'b1;
                        end
                        C_JR: begin
                            gr_sel[GR_A] = 1'b1; Rout = 1'b1; dst_en[DST_PC] = 1'b1;
                        end
                        C_MFHI: begin
                            src_en[SRC_HI] = 1'b1; gr_sel[GR_A] = 1'b1; Rin = 1'b1;
                        end
                        C_MFLO: begin
                            src_en[SRC_LO] = 1'b1; gr_sel[GR_A] = 1'b1; Rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        C_ALU3: begin
                            gr_sel[GR_C] = 1'b1; Rout = 1'b1;
                            alu_op = op_alu; dst_en[DST_Z] = 1'b1;
                        end
                        C_IMM, C_LD, C_LDI, C_ST: begin
                            src_en[SRC_C] = 1'b1; alu_op = op_alu; dst_en[DST_Z] = 1'b1;
                        end
                        C_MULDIV: begin
                            gr_sel[GR_B] = 1'b1; Rout = 1'b1;
                            alu_op = op_alu; dst_en[DST_Z] = 1'b1;
                        end
                        C_UNARY: begin
                            src_en[SRC_ZLO] = 1'b1; gr_sel[GR_A] = 1'b1; Rin = 1'b1;
                        end
                        C_BR: begin
                            src_en[SRC_PC] = 1'b1; dst_en[DST_Y] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        C_ALU3, C_IMM, C_LDI: begin
                            src_en[SRC_ZLO] = 1'b1; gr_sel[GR_A] = 1'b1; Rin = 1'b1;
                        end
                        C_MULDIV: begin
                            src_en[SRC_ZLO] = 1'b1; dst_en[DST_LO] = 1'b1;
                        end
                        C_LD, C_ST: begin
                            src_en[SRC_ZLO] = 1'b1; dst_en[DST_MAR] = 1'b1;
                        end
                        C_BR: begin
                            src_en[SRC_C] = 1'b1; alu_op = op_alu; dst_en[DST_Z] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        C_MULDIV: begin
                            src_en[SRC_ZHI] = 1'b1; dst_en[DST_HI] = 1'b1;
                        end
                        C_LD: begin
                            read = 1'b1; dst_en[DST_MDR] = 1'b1;
                        end
                        C_ST: begin
                            gr_sel[GR_A] = 1'b1; Rout = 1'b1; dst_en[DST_MDR] = 1'b1;
                        end
                        C_BR: begin
                            // branch target commits only on the registered condition
                            src_en[SRC_ZLO] = con_q;
                            dst_en[DST_PC]  = con_q;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        C_LD: begin
                            src_en[SRC_MDR] = 1'b1; gr_sel[GR_A] = 1'b1; Rin = 1'b1;
                        end
                        C_ST: write = 1'b1;
                        default: ;
                    endcase
                end
                S_HALT: run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the 32-bit CPU: state register, next-state
// logic and the registered branch condition; strobe decode lives in ctrl_decode.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            clear,
    input  logic [IRW-1:0]  IR,
    input  logic            con,
    output logic [NSRC-1:0] src_en,
    output logic [NDST-1:0] dst_en,
    output logic            CONin,
    output logic [2:0]      gr_sel,
    output logic            Rin,
    output logic            Rout,
    output logic            read,
    output logic            write,
    output logic [NALU-1:0] alu_op,
    output logic            run
);

    state_t          state;
    state_t          state_nx;
    logic            con_q;
    logic [OPW-1:0]  op;
    op_class_t       cls;
    logic            unused_ir;

    assign op        = IR[IRW-1:OP_LSB];
    assign cls       = classify(op);
    assign unused_ir = ^IR[OP_LSB-1:0];

    // State register; clear aborts any instruction and restarts fetch
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_T0;
            con_q <= 1'b0;
        end else begin
            state <= state_nx;
            con_q <= con;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_T0:   state_nx = S_T1;
            S_T1:   state_nx = S_T2;
            S_T2:   state_nx = S_T3;
            S_T7:   state_nx = S_T0;
            S_HALT: state_nx = S_HALT;
            S_T3, S_T4, S_T5, S_T6: begin
                if (state == S_T3 && cls == C_HALT)
                    state_nx = S_HALT;
                else if (state[2:0] == last_step(cls))
                    state_nx = S_T0;
                else
                    state_nx = state_t'(4'(state + 4'd1));
            end
            default: state_nx = S_T0;
        endcase
    end

    ctrl_decode u_decode (
        .state  (state),
        .op     (op),
        .con_q  (con_q),
        .clear  (clear),
        .src_en (src_en),
        .dst_en (dst_en),
        .CONin  (CONin),
        .gr_sel (gr_sel),
        .Rin    (Rin),
        .Rout   (Rout),
        .read   (read),
        .write  (write),
        .alu_op (alu_op),
        .run    (run)
    );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected strobe
// vector for each cycle; a negedge monitor pops and compares.
module tb_control_unit;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic        conin;
        logic [2:0]  gr;
        logic        rin;
        logic        rout;
        logic        rd;
        logic        wr;
        logic [12:0] alu;
        logic        run;
    } exp_t;

    localparam logic [7:0] S_BA = 8'h80, S_C = 8'h40, S_MDR = 8'h20, S_PC = 8'h10;
    localparam logic [7:0] S_ZL = 8'h08, S_ZH = 8'h04, S_LO = 8'h02, S_HI = 8'h01;
    localparam logic [7:0] D_MDR = 8'h80, D_Z = 8'h40, D_LO = 8'h20, D_HI = 8'h10;
    localparam logic [7:0] D_Y = 8'h08, D_MAR = 8'h04, D_IR = 8'h02, D_PC = 8'h01;
    localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001, G0 = 3'b000;
    // flags: {CONin, Rin, Rout, read, write}
    localparam logic [4:0] F0 = 5'b00000, F_CON = 5'b10000, F_RIN = 5'b01000;
    localparam logic [4:0] F_ROUT = 5'b00100, F_RD = 5'b00010, F_WR = 5'b00001;
    localparam logic [12:0] A0 = 13'h0, A_ADD = 13'h0004, A_MUL = 13'h0010;
    localparam logic [12:0] A_NEG = 13'h0400, A_INC = 13'h1000;

    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_LD   = 32'h00800055;
    localparam logic [31:0] IR_ST   = 32'h10000000;
    localparam logic [31:0] IR_BR   = 32'h90000000;
    localparam logic [31:0] IR_MUL  = 32'h70000000;
    localparam logic [31:0] IR_NEG  = 32'h80000000;
    localparam logic [31:0] IR_NOP  = 32'hC8000000;
    localparam logic [31:0] IR_HALT = 32'hD0000000;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        con = 1'b0;
    logic [7:0]  src_en, dst_en;
    logic        CONin, Rin, Rout, read, write, run;
    logic [2:0]  gr_sel;
    logic [12:0] alu_op;

    int checks = 0;
    int failures = 0;
    exp_t  sbq[$];
    string nameq[$];

    control_unit dut (
        .clk(clk), .clear(clear), .IR(IR), .con(con),
        .src_en(src_en), .dst_en(dst_en), .CONin(CONin), .gr_sel(gr_sel),
        .Rin(Rin), .Rout(Rout), .read(read), .write(write),
        .alu_op(alu_op), .run(run)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [7:0] s, input logic [7:0] d, input logic [2:0] g,
                                input logic [4:0] f, input logic [12:0] a);
        exp_t e;
        e.src = s; e.dst = d; e.gr = g; e.alu = a; e.run = 1'b1;
        {e.conin, e.rin, e.rout, e.rd, e.wr} = f;
        return e;
    endfunction

    function automatic exp_t idle(input logic rn);
        exp_t e;
        e = '0;
        e.run = rn;
        return e;
    endfunction

    task automatic cyc(input logic clr, input logic [31:0] ir, input logic c,
                       input exp_t e, input string nm);
        @(posedge clk);
        #1;
        clear = clr; IR = ir; con = c;
        sbq.push_back(e);
        nameq.push_back(nm);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic c, input string nm);
        cyc(1'b0, ir, c, ex(S_PC, D_MAR | D_Z, G0, F0, A_INC), {nm, "_T0"});
        cyc(1'b0, ir, c, ex(S_ZL, D_PC | D_MDR, G0, F_RD, A0), {nm, "_T1"});
        cyc(1'b0, ir, c, ex(S_MDR, D_IR, G0, F0, A0), {nm, "_T2"});
    endtask

    // Shared prefix of ld/st address computation (T3..T5)
    task automatic addr_steps(input logic [31:0] ir, input string nm);
        cyc(1'b0, ir, 1'b0, ex(S_BA, D_Y, GB, F0, A0), {nm, "_T3"});
        cyc(1'b0, ir, 1'b0, ex(S_C, D_Z, G0, F0, A_ADD), {nm, "_T4"});
        cyc(1'b0, ir, 1'b0, ex(S_ZL, D_MAR, G0, F0, A0), {nm, "_T5"});
    endtask

    task automatic br_instr(input logic c, input string nm);
        fetch(IR_BR, c, nm);
        cyc(1'b0, IR_BR, c, ex(8'h0, 8'h0, GA, F_CON | F_ROUT, A0), {nm, "_T3"});
        cyc(1'b0, IR_BR, c, ex(S_PC, D_Y, G0, F0, A0), {nm, "_T4"});
        cyc(1'b0, IR_BR, c, ex(S_C, D_Z, G0, F0, A_ADD), {nm, "_T5"});
        if (c) cyc(1'b0, IR_BR, c, ex(S_ZL, D_PC, G0, F0, A0), {nm, "_T6"});
        else   cyc(1'b0, IR_BR, c, idle(1'b1), {nm, "_T6"});
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t  e, a;
            string nm;
            e  = sbq.pop_front();
            nm = nameq.pop_front();
            a  = exp_t'({src_en, dst_en, CONin, gr_sel, Rin, Rout, read, write, alu_op, run});
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got src=%h dst=%h con=%b gr=%b rin=%b rout=%b rd=%b wr=%b alu=%h run=%b, want src=%h dst=%h con=%b gr=%b rin=%b rout=%b rd=%b wr=%b alu=%h run=%b",
                         nm, a.src, a.dst, a.conin, a.gr, a.rin, a.rout, a.rd, a.wr, a.alu, a.run,
                         e.src, e.dst, e.conin, e.gr, e.rin, e.rout, e.rd, e.wr, e.alu, e.run);
            end
        end
    end

    initial begin
        cyc(1'b1, 32'h0, 1'b0, idle(1'b1), "reset0");
        cyc(1'b1, 32'h0, 1'b0, idle(1'b1), "reset1");

        fetch(IR_ADD, 1'b0, "add");
        cyc(1'b0, IR_ADD, 1'b0, ex(8'h0, D_Y, GB, F_ROUT, A0), "add_T3");
        cyc(1'b0, IR_ADD, 1'b0, ex(8'h0, D_Z, GC, F_ROUT, A_ADD), "add_T4");
        cyc(1'b0, IR_ADD, 1'b0, ex(S_ZL, 8'h0, GA, F_RIN, A0), "add_T5");

        fetch(IR_LD, 1'b0, "ld");
        addr_steps(IR_LD, "ld");
        cyc(1'b0, IR_LD, 1'b0, ex(8'h0, D_MDR, G0, F_RD, A0), "ld_T6");
        cyc(1'b0, IR_LD, 1'b0, ex(S_MDR, 8'h0, GA, F_RIN, A0), "ld_T7");

        fetch(IR_ST, 1'b0, "st");
        addr_steps(IR_ST, "st");
        cyc(1'b0, IR_ST, 1'b0, ex(8'h0, D_MDR, GA, F_ROUT, A0), "st_T6");
        cyc(1'b0, IR_ST, 1'b0, ex(8'h0, 8'h0, G0, F_WR, A0), "st_T7");

        br_instr(1'b0, "br0");
        br_instr(1'b1, "br1");

        fetch(IR_MUL, 1'b0, "mul");
        cyc(1'b0, IR_MUL, 1'b0, ex(8'h0, D_Y, GA, F_ROUT, A0), "mul_T3");
        cyc(1'b0, IR_MUL, 1'b0, ex(8'h0, D_Z, GB, F_ROUT, A_MUL), "mul_T4");
        cyc(1'b0, IR_MUL, 1'b0, ex(S_ZL, D_LO, G0, F0, A0), "mul_T5");
        cyc(1'b0, IR_MUL, 1'b0, ex(S_ZH, D_HI, G0, F0, A0), "mul_T6");

        fetch(IR_NEG, 1'b0, "neg");
        cyc(1'b0, IR_NEG, 1'b0, ex(8'h0, D_Z, GB, F_ROUT, A_NEG), "neg_T3");
        cyc(1'b0, IR_NEG, 1'b0, ex(S_ZL, 8'h0, GA, F_RIN, A0), "neg_T4");

        fetch(IR_NOP, 1'b0, "nop");
        cyc(1'b0, IR_NOP, 1'b0, idle(1'b1), "nop_T3");

        fetch(IR_HALT, 1'b0, "halt");
        cyc(1'b0, IR_HALT, 1'b0, idle(1'b1), "halt_T3");
        cyc(1'b0, IR_HALT, 1'b0, idle(1'b0), "halt_H0");
        cyc(1'b0, IR_HALT, 1'b0, idle(1'b0), "halt_H1");
        cyc(1'b1, IR_HALT, 1'b0, idle(1'b1), "halt_clear");

        fetch(IR_LD, 1'b0, "ldab");
        cyc(1'b0, IR_LD, 1'b0, ex(S_BA, D_Y, GB, F0, A0), "ldab_T3");
        cyc(1'b0, IR_LD, 1'b0, ex(S_C, D_Z, G0, F0, A_ADD), "ldab_T4");
        cyc(1'b1, IR_LD, 1'b0, idle(1'b1), "ldab_clearT5");
        fetch(IR_ST, 1'b0, "after_abort");

        @(posedge clk);
        @(posedge clk);
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
